median3x3_engine: RTL

Scan controller and pipelined 3×3 median datapath that sits directly downstream of the image memory's sliding-window read port. It issues `rd` with window top-left addresses, receives the nine window pixels `sw_pixel_1..9`, computes their median, and writes it back through the memory's write port (`wr`, `addr_row_w`, `addr_col_w`, `cl_pixel`) at the window-centre coordinate. One `start` pulse processes a full frame.

---
 rtl/median3x3_engine_pkg.sv | 33 +++
 rtl/median3x3_engine_if.sv | 27 ++
 rtl/median3x3_engine_med3_sort.sv | 25 ++
 rtl/median3x3_engine.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/median3x3_engine_pkg.sv
// Shared types and helpers for the 3x3 median scan engine.
package median_pkg;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 8;
    localparam int MED_STAGES = 3;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        pix_t lo;
        pix_t hi;
    } pair_t;

    function automatic pair_t cmp_swap(input pix_t a, input pix_t b);
        pair_t p;
        if (a < b) begin
            p.lo = a;
            p.hi = b;
        end else begin
            p.lo = b;
            p.hi = a;
        end
        return p;
    endfunction
endpackage

// File: rtl/median3x3_engine_if.sv
// Sliding-window read port and write-back port between the engine and image memory.
interface median3x3_engine_if;
    import median_pkg::*;

    logic  rd;
    addr_t addr_row_r;
    addr_t addr_col_r;
    pix_t  sw_pixel_1, sw_pixel_2, sw_pixel_3;
    pix_t  sw_pixel_4, sw_pixel_5, sw_pixel_6;
    pix_t  sw_pixel_7, sw_pixel_8, sw_pixel_9;
    logic  wr;
    addr_t addr_row_w;
    addr_t addr_col_w;
    pix_t  cl_pixel;

    modport master (
        output rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel,
        input  sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5,
               sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9
    );

    modport slave (
        input  rd, addr_row_r, addr_col_r, wr, addr_row_w, addr_col_w, cl_pixel,
        output sw_pixel_1, sw_pixel_2, sw_pixel_3, sw_pixel_4, sw_pixel_5,
               sw_pixel_6, sw_pixel_7, sw_pixel_8, sw_pixel_9
    );
endinterface

// File: rtl/median3x3_engine_med3_sort.sv
// Combinational three-input sorter built from three compare-exchange cells.
module med3_sort
    import median_pkg::*;
(
    input  pix_t a,
    input  pix_t b,
    input  pix_t c,
    output pix_t lo,
    output pix_t mid,
    output pix_t hi
);
    pair_t p_ab;
    pair_t p_hc;
    pair_t p_lo;

    always_comb begin
        p_ab = cmp_swap(a, b);
        p_hc = cmp_swap(p_ab.hi, c);
        p_lo = cmp_swap(p_ab.lo, p_hc.lo);
    end

    assign lo  = p_lo.lo;
    assign mid = p_lo.hi;
    assign hi  = p_hc.hi;
endmodule

// File: rtl/median3x3_engine.sv
// Frame scan controller plus 3-stage 3x3 median pipeline.
// state | meaning: IDLE wait start | SCAN one rd per cycle | DRAIN flush pipeline | DONE pulse done
module median3x3_engine
    import median_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    median3x3_engine_if.master  mem
);
    localparam addr_t COL_LAST = addr_t'(IMG_W - 3);
    localparam addr_t ROW_LAST = addr_t'(IMG_H - 3);
    // Entries ahead of the wr register; together with wr the line is RD_LAT+3 deep.
    localparam int    DL       = RD_LAT + MED_STAGES - 1;

    state_t          state;
    logic [DL-1:0]   vld_d;
    addr_t           row_d [DL];
    addr_t           col_d [DL];

    pix_t win [9];
    pix_t s1_lo [3], s1_mid [3], s1_hi [3];
    pix_t r1_lo [3], r1_mid [3], r1_hi [3];
    pix_t s2_max, s2_med, s2_min;
    pix_t r2_max, r2_med, r2_min;
    pix_t s3_med;
    pix_t s2_unused [6];
    pix_t s3_unused [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem.rd         <= 1'b0;
            mem.addr_row_r <= '0;
            mem.addr_col_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state          <= ST_SCAN;
                        busy           <= 1'b1;
                        mem.rd         <= 1'b1;
                        mem.addr_row_r <= '0;
                        mem.addr_col_r <= '0;
                    end
                end
                ST_SCAN: begin
                    if (mem.addr_row_r == ROW_LAST && mem.addr_col_r == COL_LAST) begin
                        mem.rd <= 1'b0;
                        state  <= ST_DRAIN;
                    end else if (mem.addr_col_r == COL_LAST) begin
                        mem.addr_col_r <= '0;
                        mem.addr_row_r <= mem.addr_row_r + addr_t'(1);
                    end else begin
                        mem.addr_col_r <= mem.addr_col_r + addr_t'(1);
                    end
                end
                ST_DRAIN: begin
                    // Line empty means the last wr is on the port this cycle.
                    if (vld_d == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_d          <= '0;
            for (int i = 0; i < DL; i++) begin
                row_d[i] <= '0;
                col_d[i] <= '0;
            end
            mem.wr         <= 1'b0;
            mem.addr_row_w <= '0;
            mem.addr_col_w <= '0;
            mem.cl_pixel   <= '0;
        end else begin
            vld_d    <= {vld_d[DL-2:0], mem.rd};
            row_d[0] <= mem.addr_row_r;
            col_d[0] <= mem.addr_col_r;
            for (int i = 1; i < DL; i++) begin
                row_d[i] <= row_d[i-1];
                col_d[i] <= col_d[i-1];
            end
            mem.wr <= vld_d[DL-1];
            if (vld_d[DL-1]) begin
                mem.addr_row_w <= row_d[DL-1] + addr_t'(1);
                mem.addr_col_w <= col_d[DL-1] + addr_t'(1);
                mem.cl_pixel   <= s3_med;
            end
        end
    end

    assign win = '{mem.sw_pixel_1, mem.sw_pixel_2, mem.sw_pixel_3,
                   mem.sw_pixel_4, mem.sw_pixel_5, mem.sw_pixel_6,
                   mem.sw_pixel_7, mem.sw_pixel_8, mem.sw_pixel_9};

    for (genvar g = 0; g < 3; g++) begin : g_row
        med3_sort u_row_sort (
            .a(win[3*g]), .b(win[3*g+1]), .c(win[3*g+2]),
            .lo(s1_lo[g]), .mid(s1_mid[g]), .hi(s1_hi[g])
        );
    end

    med3_sort u_lo_sort (
        .a(r1_lo[0]), .b(r1_lo[1]), .c(r1_lo[2]),
        .lo(s2_unused[0]), .mid(s2_unused[1]), .hi(s2_max)
    );
    med3_sort u_mid_sort (
        .a(r1_mid[0]), .b(r1_mid[1]), .c(r1_mid[2]),
        .lo(s2_unused[2]), .mid(s2_med), .hi(s2_unused[3])
    );
    med3_sort u_hi_sort (
        .a(r1_hi[0]), .b(r1_hi[1]), .c(r1_hi[2]),
        .lo(s2_min), .mid(s2_unused[4]), .hi(s2_unused[5])
    );
    med3_sort u_final_sort (
        .a(r2_max), .b(r2_med), .c(r2_min),
        .lo(s3_unused[0]), .mid(s3_med), .hi(s3_unused[1])
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                r1_lo[i]  <= '0;
                r1_mid[i] <= '0;
                r1_hi[i]  <= '0;
            end
            r2_max <= '0;
            r2_med <= '0;
            r2_min <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r1_lo[i]  <= s1_lo[i];
                r1_mid[i] <= s1_mid[i];
                r1_hi[i]  <= s1_hi[i];
            end
            r2_max <= s2_max;
            r2_med <= s2_med;
            r2_min <= s2_min;
        end
    end
endmodule
